alu_acc_seq: RTL and testbench

- Registered, sequenced ALU stage that consumes the 4-bit combinational ALU function set and latches its result.
- The low nibble of the registered result feeds back as operand B, so the block works as a 4-bit accumulator.
- Adds a Start/Busy/Done handshake and a multi-cycle unsigned multiply.
- Sits between operand/switch input logic and the hex-display and LED output stage.

---
 rtl/alu_acc_seq_pkg.sv | 21 ++
 rtl/alu_acc_seq_alu4_comb.sv | 70 +++++++
 rtl/alu_acc_seq.sv | 92 +++++++++
 tb/tb_alu_acc_seq.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/alu_acc_seq_pkg.sv
// Shared opcodes, FSM state encoding and multiply step count for the
// sequenced accumulator ALU.
package alu_acc_seq_pkg;

  localparam int MUL_STEPS_DEF = 4;

  localparam logic [2:0] OP_RIPPLE = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SEXT   = 3'b010;
  localparam logic [2:0] OP_OR     = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_CAT    = 3'b101;
  localparam logic [2:0] OP_MUL    = 3'b110;
  localparam logic [2:0] OP_HOLD   = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_acc_seq_alu4_comb.sv
// Combinational 4-bit ALU covering every single-cycle opcode. The multiply
// lives in the top level; for OP_MUL and OP_HOLD this block returns the
// current result unchanged.

module alu_acc_seq_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module alu_acc_seq_ripple4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = 1'b0;
  assign co   = c[4];

  for (genvar i = 0; i < 4; i++) begin : g_fa
    alu_acc_seq_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end
endmodule

module alu4_comb
  import alu_acc_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  input  logic [7:0] hold,
  output logic [7:0] result
);
  logic [3:0] rip_sum;
  logic       rip_co;

  alu_acc_seq_ripple4 u_rip (
    .a   (a),
    .b   (b),
    .sum (rip_sum),
    .co  (rip_co)
  );

  // Opcode select; anything not handled here leaves the result untouched.
  always_comb begin
    result = hold;
    case (op)
      OP_RIPPLE: result = {3'b000, rip_co, rip_sum};
      OP_ADD:    result = {3'b000, ({1'b0, a} + {1'b0, b})};
      OP_SEXT:   result = {{4{b[3]}}, b};
      OP_OR:     result = {7'b0, |{a, b}};
      OP_AND:    result = {7'b0, &{a, b}};
      OP_CAT:    result = {a, b};
      default:   result = hold;
    endcase
  end
endmodule

// File: rtl/alu_acc_seq.sv
// Registered accumulator ALU with Start/Busy/Done handshake and a shift-add
// multiply. ALUout[3:0] is fed back as operand B.
//
//   state  | meaning
//   S_IDLE | waiting for Start; single-cycle ops complete here
//   S_MUL  | shift-add multiply in progress, Start ignored
module alu_acc_seq
  import alu_acc_seq_pkg::*;
#(
  parameter int MUL_STEPS = MUL_STEPS_DEF
) (
  input  logic       Clock,
  input  logic       Reset_b,
  input  logic [3:0] A,
  input  logic [2:0] Function,
  input  logic       Start,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] ALUout
);
  localparam int              CNT_W    = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       p;
  logic [7:0]       m;
  logic [3:0]       q;
  logic [7:0]       p_next;
  logic [7:0]       alu_res;

  alu4_comb u_alu (
    .a      (A),
    .b      (ALUout[3:0]),
    .op     (Function),
    .hold   (ALUout),
    .result (alu_res)
  );

  // Partial product after this step's conditional add.
  always_comb begin
    p_next = p;
    if (q[0]) p_next = p + m;
  end

  // Handshake FSM, result register and multiply datapath.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state  <= S_IDLE;
      cnt    <= '0;
      p      <= '0;
      m      <= '0;
      q      <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      ALUout <= 8'h00;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (Function == OP_MUL) begin
              // B is frozen into q here so later result writes cannot disturb it.
              p     <= '0;
              m     <= {4'b0000, A};
              q     <= ALUout[3:0];
              cnt   <= '0;
              Busy  <= 1'b1;
              state <= S_MUL;
            end else begin
              ALUout <= alu_res;
              Done   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          p   <= p_next;
          m   <= m << 1;
          q   <= q >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            ALUout <= p_next;
            Done   <= 1'b1;
            Busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for alu_acc_seq: expected results are queued when an
// operation is launched and popped when Done is seen.
module tb_alu_acc_seq;
  import alu_acc_seq_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset_b = 1'b1;
  logic [3:0] A = 4'h0;
  logic [2:0] Function = 3'b000;
  logic       Start = 1'b0;
  logic       Busy;
  logic       Done;
  logic [7:0] ALUout;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];

  always #5 Clock = ~Clock;

  alu_acc_seq #(.MUL_STEPS(4)) dut (
    .Clock    (Clock),
    .Reset_b  (Reset_b),
    .A        (A),
    .Function (Function),
    .Start    (Start),
    .Busy     (Busy),
    .Done     (Done),
    .ALUout   (ALUout)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = 8'hxx;
    if (sb.size() > 0) e = sb.pop_front();
    check(tag, ALUout, e);
  endtask

  // Launch one op, wait for Done (bounded), verify busy length and result.
  // With poke set, a Start with OP_ADD is pulsed while the op is busy.
  task automatic run_op(input logic [3:0] a, input logic [2:0] fn, input logic [7:0] exp,
                        input int exp_busy, input bit poke, input string tag);
    int n;
    int bc;
    @(negedge Clock);
    A = a; Function = fn; Start = 1'b1;
    sb.push_back(exp);
    @(negedge Clock);
    Start = 1'b0;
    n = 0; bc = 0;
    while (!Done && n < 20) begin
      if (Busy) bc++;
      if (poke) begin
        Start = (n == 1);
        Function = OP_ADD;
        A = 4'h1;
      end
      n++;
      @(negedge Clock);
    end
    Start = 1'b0;
    check({tag, "_timeout"}, 8'(n < 20), 8'd1);
    check({tag, "_busy"}, 8'(bc), 8'(exp_busy));
    pop_check(tag);
    @(negedge Clock);
    check({tag, "_done_pulse"}, 8'(Done), 8'd0);
    check({tag, "_after"}, ALUout, exp);
  endtask

  initial begin
    int dseen;

    // Asynchronous reset mid-cycle, away from any clock edge.
    #3 Reset_b = 1'b0;
    #1;
    check("rst_alu", ALUout, 8'h00);
    check("rst_busy", 8'(Busy), 8'd0);
    check("rst_done", 8'(Done), 8'd0);
    @(negedge Clock);
    Reset_b = 1'b1;

    run_op(4'h5, OP_RIPPLE, 8'h05, 0, 1'b0, "ripple_5");
    run_op(4'hF, OP_RIPPLE, 8'h14, 0, 1'b0, "ripple_carry");
    run_op(4'h8, OP_ADD,    8'h0C, 0, 1'b0, "add_0c");
    run_op(4'h0, OP_SEXT,   8'hFC, 0, 1'b0, "sext");
    run_op(4'h3, OP_CAT,    8'h3C, 0, 1'b0, "cat");
    run_op(4'h3, OP_AND,    8'h00, 0, 1'b0, "and");
    run_op(4'h3, OP_OR,     8'h01, 0, 1'b0, "or");
    run_op(4'hC, OP_ADD,    8'h0D, 0, 1'b0, "add_0d");
    run_op(4'hB, OP_MUL,    8'h8F, 4, 1'b1, "mul_b_d");
    run_op(4'hF, OP_MUL,    8'hE1, 4, 1'b0, "mul_f_f");
    run_op(4'h6, OP_HOLD,   8'hE1, 0, 1'b0, "hold");

    // Start held high: the op re-executes every edge, accumulating B=1 upward.
    @(negedge Clock);
    A = 4'h1; Function = OP_RIPPLE; Start = 1'b1;
    sb.push_back(8'h02); sb.push_back(8'h03); sb.push_back(8'h04);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      if (i == 2) Start = 1'b0;
      check("held_done", 8'(Done), 8'd1);
      pop_check("held_acc");
    end
    @(negedge Clock);
    check("held_stop_done", 8'(Done), 8'd0);
    check("held_stop_alu", ALUout, 8'h04);

    // Reset two cycles into a multiply aborts it with no Done.
    @(negedge Clock);
    A = 4'h3; Function = OP_MUL; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    check("abort_busy_pre", 8'(Busy), 8'd1);
    @(negedge Clock);
    #2 Reset_b = 1'b0;
    #1;
    check("abort_alu", ALUout, 8'h00);
    check("abort_busy", 8'(Busy), 8'd0);
    check("abort_done", 8'(Done), 8'd0);
    @(negedge Clock);
    Reset_b = 1'b1;
    dseen = 0;
    repeat (6) begin
      @(negedge Clock);
      if (Done) dseen++;
    end
    check("abort_no_done", 8'(dseen), 8'd0);
    check("abort_alu_kept", ALUout, 8'h00);

    run_op(4'h7, OP_RIPPLE, 8'h07, 0, 1'b0, "post_abort");

    check("sb_empty", 8'(sb.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
